occupancy_display: RTL

Saturating occupancy counter with a registered six-digit seven-segment front end for the lot-counter design. Takes single-cycle arrive/depart pulses, tracks occupancy from 0 to a parametrised `CAPACITY`, and drives HEX5..HEX0. Shows "CLEAr 0" when empty, the decimal count with leading-zero blanking in between, and a blinking "FULL nn" at capacity. It replaces the fixed 0–25 combinational decoder: the counter is internal, capacity is a parameter, and full blink and refusal reporting are new.

---
 rtl/occupancy_pkg.sv | 52 +++++
 rtl/occupancy_display_seg7_digit.sv | 15 +
 rtl/occupancy_display.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/occupancy_pkg.sv
// Shared definitions for the occupancy display.
//   - SEG_* : active-low seven-segment codes, bit order gfedcba
//   - disp_mode_t : which of the three display layouts is shown
//   - seg_digit() : decimal digit to segment code; non-decimal input blanks
package occupancy_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_U     = 7'b1000001;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        MODE_EMPTY   = 2'd0,
        MODE_PARTIAL = 2'd1,
        MODE_FULL    = 2'd2
    } disp_mode_t;

    function automatic logic [6:0] seg_digit(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/occupancy_display_seg7_digit.sv
// Combinational decimal digit to seven-segment decoder.
//   digit in  4 : decimal digit (values above 9 produce a blank)
//   seg   out 7 : active-low segments, gfedcba
module seg7_digit
    import occupancy_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_digit(digit);
    end

endmodule

// File: rtl/occupancy_display.sv
// Saturating occupancy counter with a registered six-digit display.
//   clk       in  1  : rising-edge clock
//   reset     in  1  : synchronous active-high reset
//   inc/dec   in  1  : arrival / departure pulses
//   count     out CW : current occupancy
//   full      out 1  : count == CAPACITY
//   empty     out 1  : count == 0
//   rejected  out 1  : one-cycle pulse on inc-at-full or dec-at-empty
//   HEX0..5   out 7  : active-low segments (gfedcba), one register stage
//                      behind count
// Display shows "CLEAr 0" when empty, the blanked decimal count when
// partially occupied, and "FULL nn" at capacity with the word blinking.
module occupancy_display
    import occupancy_pkg::*;
#(
    parameter  int CAPACITY     = 25,
    parameter  int BLINK_CYCLES = 25_000_000,
    localparam int CW           = $clog2(CAPACITY + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          rejected,
    output logic [6:0]    HEX0,
    output logic [6:0]    HEX1,
    output logic [6:0]    HEX2,
    output logic [6:0]    HEX3,
    output logic [6:0]    HEX4,
    output logic [6:0]    HEX5
);

    localparam int            BW         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CW-1:0] CAP_VAL    = CW'(CAPACITY);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    // HEX5..HEX0 shown while empty; also loaded directly by reset.
    localparam logic [5:0][6:0] EMPTY_PATTERN = {SEG_C, SEG_L, SEG_E, SEG_A, SEG_R, SEG_0};

    // ------------------------------------------------------------------
    // Occupancy counter
    // ------------------------------------------------------------------
    logic [CW-1:0] count_reg, count_next;
    logic          full_reg, empty_reg;
    logic          rejected_reg, rejected_next;

    // Simultaneous inc and dec cancel out and are never refused.
    always_comb begin
        count_next    = count_reg;
        rejected_next = 1'b0;
        if (inc && !dec) begin
            if (full_reg) rejected_next = 1'b1;
            else          count_next    = count_reg + CW'(1);
        end else if (dec && !inc) begin
            if (empty_reg) rejected_next = 1'b1;
            else           count_next    = count_reg - CW'(1);
        end
    end

    // Flags are derived from count_next so they stay aligned with count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            rejected_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            full_reg     <= (count_next == CAP_VAL);
            empty_reg    <= (count_next == '0);
            rejected_reg <= rejected_next;
        end
    end

    assign count    = count_reg;
    assign full     = full_reg;
    assign empty    = empty_reg;
    assign rejected = rejected_reg;

    // ------------------------------------------------------------------
    // Blink timer: free-runs only while full, parked at the visible phase
    // otherwise so every entry into FULL starts with the word lit.
    // ------------------------------------------------------------------
    logic [BW-1:0] blink_cnt_reg;
    logic          phase_reg;

    always_ff @(posedge clk) begin
        if (reset || !full_reg) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            phase_reg     <= ~phase_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + BW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Decimal split and digit decoders (index 0 = ones, 1 = tens)
    // ------------------------------------------------------------------
    logic [6:0] count_ext;
    logic [3:0] digit_val [2];
    logic [6:0] digit_seg [2];

    // Widened to 7 bits so the constant 10 is representable for any CW.
    assign count_ext    = 7'(count_reg);
    assign digit_val[0] = 4'(count_ext % 7'd10);
    assign digit_val[1] = 4'(count_ext / 7'd10);

    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
        seg7_digit u_digit (
            .digit (digit_val[gi]),
            .seg   (digit_seg[gi])
        );
    end

    // ------------------------------------------------------------------
    // Mode selection and display register
    // ------------------------------------------------------------------
    disp_mode_t       mode;
    logic [5:0][6:0]  hex_next;
    logic [5:0][6:0]  hex_reg;
    logic [6:0]       tens_seg;

    always_comb begin
        mode = MODE_PARTIAL;
        if (empty_reg)     mode = MODE_EMPTY;
        else if (full_reg) mode = MODE_FULL;
    end

    // Leading-zero blanking of the tens digit; also covers CAPACITY < 10.
    assign tens_seg = (count_ext < 7'd10) ? SEG_BLANK : digit_seg[1];

    always_comb begin
        hex_next = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, tens_seg, digit_seg[0]};
        case (mode)
            MODE_EMPTY: begin
                hex_next = EMPTY_PATTERN;
            end
            MODE_FULL: begin
                if (!phase_reg) begin
                    hex_next[5] = SEG_F;
                    hex_next[4] = SEG_U;
                    hex_next[3] = SEG_L;
                    hex_next[2] = SEG_L;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) hex_reg <= EMPTY_PATTERN;
        else       hex_reg <= hex_next;
    end

    assign HEX0 = hex_reg[0];
    assign HEX1 = hex_reg[1];
    assign HEX2 = hex_reg[2];
    assign HEX3 = hex_reg[3];
    assign HEX4 = hex_reg[4];
    assign HEX5 = hex_reg[5];

endmodule
